// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the async FIFO read port (1-cycle latency) into a valid/ready stream.
// Optional accepted-beat counter enabled by defining FRS_BEAT_CNT_EN.
module fifo_rd_stream #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned OCC_W = 3;

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             m_valid_q, m_valid_d;
  logic [DSIZE-1:0] m_data_q, m_data_d;
  logic             capture;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue only when a slot is guaranteed for the returning word; independent of m_ready.
  assign fifo_rd_en = rd_rst_n && !fifo_empty && !flush &&
                      ((OCC_W'(count_q) + OCC_W'(pend_q)) < OCC_W'(DEPTH));

  assign capture = pend_q && !flush;
  assign pop     = m_valid_q && m_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pend_d  = fifo_rd_en;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = 1'b0;
    end else begin
      if (capture) begin
        mem_d[tail_q] = fifo_rd_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + PTR_W'(capture) - PTR_W'(pop);
    end
    // Output view of the next state, so m_valid/m_data come straight from flops.
    m_valid_d = (count_d != '0);
    m_data_d  = mem_d[head_d];
  end

  always_ff @(posedge rd_clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef FRS_BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Survives flush; only reset clears it.
  always_comb beat_cnt_d = beat_cnt_q + CNT_W'(pop);

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) beat_cnt_q <= '0;
    else           beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule
